// File: rtl/regfile_seq.sv
// Register-file sequencer: two reads time-multiplexed over one RAM read port, then an optional write strobe.
// Latency: 3 cycles without write, 4+WR_PULSE with write, accept edge to rsp_valid (REGFILE_SEQ_SKIP_X0_EN skips x0 reads).
// Backpressure: req_ready high only in IDLE; exactly one operation in flight.
module regfile_seq #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 5,
   parameter int WR_PULSE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic [ADDR_W-1:0] ram_read_addr,
   output logic [ADDR_W-1:0] ram_write_addr,
   output logic [DATA_W-1:0] ram_d_write,
   input  logic [DATA_W-1:0] ram_d_read,
   output logic              ram_nOE,
   output logic              ram_nWR
);

   typedef enum logic [2:0] {IDLE, RD1, RD2, WR, WR_REC, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rs1_q, rs1_nxt, rs2_q, rs2_nxt, rd_q, rd_nxt;
   logic              we_q, we_nxt;
   logic [DATA_W-1:0] wdat_q, wdat_nxt;
   logic [3:0]        cnt, cnt_nxt;

   logic              req_ready_nxt, rsp_valid_nxt, ram_nOE_nxt, ram_nWR_nxt;
   logic [DATA_W-1:0] rs1_data_nxt, rs2_data_nxt, ram_d_write_nxt;
   logic [ADDR_W-1:0] ram_read_addr_nxt, ram_write_addr_nxt;

   // Operation fields as seen this cycle: live inputs on the accept edge, latched copies afterwards
   logic [ADDR_W-1:0] op_rs1, op_rs2, op_rd;
   logic              op_we;
   logic [DATA_W-1:0] op_wdat;

   always_comb begin
      state_nxt          = state;
      rs1_nxt            = rs1_q;
      rs2_nxt            = rs2_q;
      rd_nxt             = rd_q;
      we_nxt             = we_q;
      wdat_nxt           = wdat_q;
      cnt_nxt            = cnt;
      rs1_data_nxt       = rs1_data;
      rs2_data_nxt       = rs2_data;
      ram_read_addr_nxt  = ram_read_addr;
      ram_write_addr_nxt = ram_write_addr;
      ram_d_write_nxt    = ram_d_write;
      op_rs1             = rs1_q;
      op_rs2             = rs2_q;
      op_rd              = rd_q;
      op_we              = we_q;
      op_wdat            = wdat_q;

      case (state)
         IDLE: begin
            if (req_valid) begin
               op_rs1   = rs1;
               op_rs2   = rs2;
               op_rd    = rd;
               op_we    = wr_en & (rd != '0);
               op_wdat  = wr_data;
               rs1_nxt  = rs1;
               rs2_nxt  = rs2;
               rd_nxt   = rd;
               we_nxt   = op_we;
               wdat_nxt = wr_data;
`ifdef REGFILE_SEQ_SKIP_X0_EN
               if (rs1 == '0) begin
                  rs1_data_nxt = '0;
                  if (rs2 == '0) begin
                     rs2_data_nxt = '0;
                     state_nxt    = op_we ? WR : DONE;
                  end else begin
                     state_nxt = RD2;
                  end
               end else begin
                  state_nxt = RD1;
               end
`else
               state_nxt = RD1;
`endif
            end
         end
         RD1: begin
            rs1_data_nxt = (rs1_q == '0) ? '0 : ram_d_read;
`ifdef REGFILE_SEQ_SKIP_X0_EN
            if (rs2_q == '0) begin
               rs2_data_nxt = '0;
               state_nxt    = we_q ? WR : DONE;
            end else begin
               state_nxt = RD2;
            end
`else
            state_nxt = RD2;
`endif
         end
         RD2: begin
            rs2_data_nxt = (rs2_q == '0) ? '0 : ram_d_read;
            state_nxt    = we_q ? WR : DONE;
         end
         WR: begin
            if (cnt == 4'd0) state_nxt = WR_REC;
            else             cnt_nxt   = cnt - 4'd1;
         end
         WR_REC:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Strobes are decoded from the next state so every output comes straight from a flop
      req_ready_nxt = (state_nxt == IDLE);
      rsp_valid_nxt = (state_nxt == DONE);
      ram_nOE_nxt   = !((state_nxt == RD1) || (state_nxt == RD2));
      ram_nWR_nxt   = (state_nxt != WR);
      if (state_nxt == RD1) ram_read_addr_nxt = op_rs1;
      if (state_nxt == RD2) ram_read_addr_nxt = op_rs2;
      if ((state_nxt == WR) && (state != WR)) begin
         ram_write_addr_nxt = op_rd;
         ram_d_write_nxt    = op_wdat;
         cnt_nxt            = 4'(WR_PULSE - 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         rs1_q          <= '0;
         rs2_q          <= '0;
         rd_q           <= '0;
         we_q           <= 1'b0;
         wdat_q         <= '0;
         cnt            <= 4'd0;
         req_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rs1_data       <= '0;
         rs2_data       <= '0;
         ram_read_addr  <= '0;
         ram_write_addr <= '0;
         ram_d_write    <= '0;
         ram_nOE        <= 1'b1;
         ram_nWR        <= 1'b1;
      end else begin
         state          <= state_nxt;
         rs1_q          <= rs1_nxt;
         rs2_q          <= rs2_nxt;
         rd_q           <= rd_nxt;
         we_q           <= we_nxt;
         wdat_q         <= wdat_nxt;
         cnt            <= cnt_nxt;
         req_ready      <= req_ready_nxt;
         rsp_valid      <= rsp_valid_nxt;
         rs1_data       <= rs1_data_nxt;
         rs2_data       <= rs2_data_nxt;
         ram_read_addr  <= ram_read_addr_nxt;
         ram_write_addr <= ram_write_addr_nxt;
         ram_d_write    <= ram_d_write_nxt;
         ram_nOE        <= ram_nOE_nxt;
         ram_nWR        <= ram_nWR_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: behavioural 32x16 RAM, vector table plus back-to-back and reset-abort sequences.
module tb_regfile_seq;

   localparam int P = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic        rsp_valid;
   logic [15:0] rs1_data, rs2_data;
   logic [4:0]  ram_read_addr, ram_write_addr;
   logic [15:0] ram_d_write, ram_d_read;
   logic        ram_nOE, ram_nWR;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_seq #(.DATA_W(16), .ADDR_W(5), .WR_PULSE(P)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .rs1(rs1), .rs2(rs2), .rd(rd), .wr_en(wr_en), .wr_data(wr_data),
      .rsp_valid(rsp_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
      .ram_d_write(ram_d_write), .ram_d_read(ram_d_read),
      .ram_nOE(ram_nOE), .ram_nWR(ram_nWR)
   );

   // RAM model: combinational read while enabled, commit on the rising edge of ram_nWR
   logic [15:0] mem [32];
   bit          ram_arm = 1'b0;
   assign ram_d_read = ram_nOE ? 16'hBAD0 : mem[ram_read_addr];
   always @(posedge ram_nWR) if (ram_arm) mem[ram_write_addr] <= ram_d_write;

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic        wr_en;
      logic [15:0] wdat, exp1, exp2, exp_mem;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input vec_t v);
      int l = 3;
      if (v.wr_en && v.rd != 0) l += 1 + P;
`ifdef REGFILE_SEQ_SKIP_X0_EN
      if (v.rs1 == 0) l--;
      if (v.rs2 == 0) l--;
`endif
      return l;
   endfunction

   function automatic int exp_reads(input vec_t v);
      int r = 2;
`ifdef REGFILE_SEQ_SKIP_X0_EN
      if (v.rs1 == 0) r--;
      if (v.rs2 == 0) r--;
`endif
      return r;
   endfunction

   task automatic run_req(input string tag, input vec_t v);
      int  w = 0, lat = 0, nwr_cnt = 0, noe_cnt = 0, hold_bad = 0;
      bit  seen = 1'b0, prev_low = 1'b0;
      bit  we = v.wr_en && (v.rd != 0);
      @(negedge clk);
      req_valid = 1'b1; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; wr_en = v.wr_en; wr_data = v.wdat;
      while (!req_ready && w < 50) begin @(negedge clk); w++; end
      check({tag, "_accept"}, 32'(w < 50), 32'd1);
      @(posedge clk);
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1) req_valid = 1'b0;
         if (!ram_nWR) nwr_cnt++;
         if (!ram_nWR || prev_low)
            if (ram_write_addr !== v.rd || ram_d_write !== v.wdat) hold_bad++;
         prev_low = !ram_nWR;
         if (!ram_nOE) noe_cnt++;
         if (rsp_valid) seen = 1'b1;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat(v)));
      check({tag, "_rs1"}, 32'(rs1_data), 32'(v.exp1));
      check({tag, "_rs2"}, 32'(rs2_data), 32'(v.exp2));
      check({tag, "_nwr"}, 32'(nwr_cnt), we ? 32'(P) : 32'd0);
      check({tag, "_noe"}, 32'(noe_cnt), 32'(exp_reads(v)));
      if (we) check({tag, "_hold"}, 32'(hold_bad), 32'd0);
      check({tag, "_mem"}, 32'(mem[v.rd]), 32'(v.exp_mem));
      @(negedge clk);
      check({tag, "_pulse"}, {30'd0, rsp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
      mem[0] = 16'hEEEE;
      mem[7] = 16'h00A5;
   end

   initial begin
      bit [11:0] rsp_pat, rdy_pat, noe_pat, rsp_exp, rdy_exp, noe_exp;
      int        w, rsp_cnt;
      vec_t      v;

      vecs[0] = '{5'd0,  5'd0,  5'd5,  1'b1, 16'hFA0F, 16'h0000, 16'h0000, 16'hFA0F};
      vecs[1] = '{5'd5,  5'd7,  5'd5,  1'b1, 16'h1234, 16'hFA0F, 16'h00A5, 16'h1234};
      vecs[2] = '{5'd0,  5'd5,  5'd0,  1'b1, 16'hFFFF, 16'h0000, 16'h1234, 16'hEEEE};
      vecs[3] = '{5'd7,  5'd7,  5'd7,  1'b0, 16'h0000, 16'h00A5, 16'h00A5, 16'h00A5};
      vecs[4] = '{5'd3,  5'd31, 5'd31, 1'b1, 16'hBEEF, 16'h1003, 16'h101F, 16'hBEEF};
      vecs[5] = '{5'd31, 5'd0,  5'd2,  1'b0, 16'h5555, 16'hBEEF, 16'h0000, 16'h1002};
      vecs[6] = '{5'd0,  5'd0,  5'd0,  1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hEEEE};

      @(negedge clk);
      check("rst_ready",  32'(req_ready), 32'd1);
      check("rst_rsp",    32'(rsp_valid), 32'd0);
      check("rst_data",   {rs1_data, rs2_data}, 32'd0);
      check("rst_addr",   {22'd0, ram_read_addr, ram_write_addr}, 32'd0);
      check("rst_dwrite", 32'(ram_d_write), 32'd0);
      check("rst_strobe", {30'd0, ram_nOE, ram_nWR}, 32'd3);
      @(negedge clk);
      rst = 1'b0;
      ram_arm = 1'b1;
      @(negedge clk);
      check("idle_strobe", {30'd0, ram_nOE, ram_nWR}, 32'd3);

      for (int i = 0; i < 7; i++) run_req($sformatf("v%0d", i), vecs[i]);

      // Back-to-back: three read-only requests with req_valid held high
      @(negedge clk);
      req_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd7; rd = 5'd0; wr_en = 1'b0;
      w = 0;
      while (!req_ready && w < 50) begin @(negedge clk); w++; end
      check("b2b_accept", 32'(w < 50), 32'd1);
      rsp_pat = '0; rdy_pat = '0; noe_pat = '0;
      rsp_exp = '0; rdy_exp = '0; noe_exp = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 12) req_valid = 1'b0;
         rsp_pat[c-1] = rsp_valid;
         rdy_pat[c-1] = req_ready;
         noe_pat[c-1] = !ram_nOE;
         rsp_exp[c-1] = (c % 4 == 3);
         rdy_exp[c-1] = (c % 4 == 0);
         noe_exp[c-1] = (c % 4 == 1) || (c % 4 == 2);
      end
      check("b2b_rsp", 32'(rsp_pat), 32'(rsp_exp));
      check("b2b_ready", 32'(rdy_pat), 32'(rdy_exp));
      check("b2b_noe", 32'(noe_pat), 32'(noe_exp));
      check("b2b_data", {rs1_data, rs2_data}, 32'h00A500A5);

      // Reset during the first write cycle
      @(negedge clk);
      req_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd9; wr_en = 1'b1; wr_data = 16'h7777;
      @(negedge clk);
      req_valid = 1'b0;
      w = 0;
      while (ram_nWR && w < 50) begin @(negedge clk); w++; end
      check("abort_wr_seen", 32'(w < 50), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_strobe", {30'd0, ram_nWR, req_ready}, 32'd3);
      check("abort_noe", 32'(ram_nOE), 32'd1);
      rsp_cnt = 0;
      repeat (2) begin @(negedge clk); rsp_cnt += 32'(rsp_valid); end
      rst = 1'b0;
      repeat (4) begin @(negedge clk); rsp_cnt += 32'(rsp_valid); end
      check("abort_no_rsp", 32'(rsp_cnt), 32'd0);
      check("abort_data", {rs1_data, rs2_data}, 32'd0);
      v = '{5'd7, 5'd31, 5'd4, 1'b1, 16'hCAFE, 16'h00A5, 16'hBEEF, 16'hCAFE};
      run_req("post_abort", v);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
